// File: rtl/nvr_pkg.sv
// Shared state encoding and default sizing/latency constants for the NVR responder.
package nvr_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ,
        ST_WRITE,
        ST_STORE,
        ST_RECALL
    } nvr_state_e;

    localparam int NVR_DEPTH     = 128;
    localparam int NVR_AW        = 7;
    localparam int NVR_DW        = 32;
    localparam int NVR_READ_LAT  = 2;
    localparam int NVR_WRITE_LAT = 4;

endpackage

// File: rtl/nvr_edge_det.sv
// Rising-edge detector for one synchronous strobe; the history bit clears on reset
// so a level already high when reset releases counts as an edge on the first clock.
module nvr_edge_det (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic rise
);

    logic prev;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) prev <= 1'b0;
        else        prev <= d;
    end

    assign rise = d & ~prev;

endmodule

// File: rtl/nvr_responder.sv
// NV-SRAM style responder: volatile word array with a shadow copy, edge-triggered
// read/write, bulk store (array -> shadow) and recall (shadow -> array).
module nvr_responder
    import nvr_pkg::*;
#(
    parameter int DEPTH     = NVR_DEPTH,
    parameter int AW        = NVR_AW,
    parameter int DW        = NVR_DW,
    parameter int READ_LAT  = NVR_READ_LAT,
    parameter int WRITE_LAT = NVR_WRITE_LAT
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [AW-1:0] A,
    input  logic [DW-1:0] DIN,
    input  logic          WE,
    input  logic          CE,
    input  logic          HS,
    input  logic          HR,
    input  logic          POR,
    output logic [DW-1:0] DOUT,
    output logic          RDY
);

    localparam int MAXLAT = (READ_LAT > WRITE_LAT) ? READ_LAT : WRITE_LAT;
    localparam int CW     = $clog2(MAXLAT + 1);

    logic [3:0]    strobe;
    logic [3:0]    rise;
    logic          ce_e, hs_e, hr_e, por_e;

    nvr_state_e    state;
    logic [CW-1:0] lat_cnt;
    logic [AW:0]   idx;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] din_q;

    logic [DW-1:0] mem    [DEPTH];
    logic [DW-1:0] shadow [DEPTH];

    logic          mem_we;
    logic [AW-1:0] mem_wa;
    logic [DW-1:0] mem_wd;

    assign strobe = {POR, HR, HS, CE};

    for (genvar g = 0; g < 4; g++) begin : g_edge
        nvr_edge_det u_edge (
            .clk   (clk),
            .reset (reset),
            .d     (strobe[g]),
            .rise  (rise[g])
        );
    end

    assign {por_e, hr_e, hs_e, ce_e} = rise;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= ST_IDLE;
            RDY     <= 1'b1;
            DOUT    <= '0;
            lat_cnt <= '0;
            idx     <= '0;
            addr_q  <= '0;
            din_q   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    // Losing edges in the same cycle are simply dropped.
                    if (por_e || hr_e) begin
                        state <= ST_RECALL;
                        idx   <= '0;
                        RDY   <= 1'b0;
                    end else if (hs_e) begin
                        state <= ST_STORE;
                        idx   <= '0;
                        RDY   <= 1'b0;
                    end else if (ce_e) begin
                        addr_q <= A;
                        RDY    <= 1'b0;
                        if (WE) begin
                            din_q   <= DIN;
                            lat_cnt <= CW'(WRITE_LAT - 1);
                            state   <= ST_WRITE;
                        end else begin
                            lat_cnt <= CW'(READ_LAT - 1);
                            state   <= ST_READ;
                        end
                    end
                end
                ST_READ: begin
                    if (lat_cnt == '0) begin
                        DOUT  <= mem[addr_q];
                        state <= ST_IDLE;
                        RDY   <= 1'b1;
                    end else begin
                        lat_cnt <= lat_cnt - 1'b1;
                    end
                end
                ST_WRITE: begin
                    if (lat_cnt == '0) begin
                        state <= ST_IDLE;
                        RDY   <= 1'b1;
                    end else begin
                        lat_cnt <= lat_cnt - 1'b1;
                    end
                end
                ST_STORE, ST_RECALL: begin
                    if (idx == (AW+1)'(DEPTH - 1)) begin
                        idx   <= '0;
                        state <= ST_IDLE;
                        RDY   <= 1'b1;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    RDY   <= 1'b1;
                end
            endcase
        end
    end

    // Single write port on the volatile array, shared by WRITE and RECALL.
    always_comb begin
        mem_we = (state == ST_RECALL) ||
                 (state == ST_WRITE && lat_cnt == CW'(WRITE_LAT - 1));
        mem_wa = addr_q;
        mem_wd = din_q;
        if (state == ST_RECALL) begin
            mem_wa = idx[AW-1:0];
            mem_wd = shadow[idx[AW-1:0]];
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) mem[mem_wa] <= mem_wd;
    end

    always_ff @(posedge clk) begin
        if (state == ST_STORE) shadow[idx[AW-1:0]] <= mem[idx[AW-1:0]];
    end

endmodule

// File: doc/nvr_responder.md
NVR_RESPONDER -- requirements
Module: nvr_responder

Interface
REQ-001 SHALL have parameters, one per line: name, default, meaning.
- DEPTH, 128, words in the volatile array and in the non-volatile shadow array.
- AW, 7, address width; DEPTH = 2**AW.
- DW, 32, data width.
- READ_LAT, 2, cycles from CE-edge detection to DOUT valid; minimum 1.
- WRITE_LAT, 4, cycles the array write occupies; minimum 1.

REQ-002 SHALL have ports, one per line: name, direction, width, meaning.
- clk, in, 1, the block's single clock; all logic is on the rising edge.
- reset, in, 1, asynchronous, active-low reset.
- A, in, AW, word address; captured at the CE edge.
- DIN, in, DW, write data; captured at the CE edge.
- WE, in, 1, 1 = write, 0 = read; captured at the CE edge.
- CE, in, 1, access strobe; only its rising edge starts an access.
- HS, in, 1, store request: copy the volatile array to the shadow array; edge-triggered.
- HR, in, 1, recall request: copy the shadow array to the volatile array; edge-triggered.
- POR, in, 1, power-on-reset pulse; its rising edge starts a recall.
- DOUT, out, DW, read data; holds its value between reads.
- RDY, out, 1, 1 = idle and able to accept a request.

REQ-003 All inputs SHALL be synchronous to clk; the block SHALL NOT contain input synchronizers.

Function
REQ-004 SHALL register the previous values of CE, HS, HR and POR; an edge SHALL be detected when the current value is 1 and the registered value is 0.

REQ-005 SHALL implement states IDLE, READ, WRITE, STORE and RECALL; RDY SHALL be 1 only in IDLE.

REQ-006 Edge priority in IDLE SHALL be POR > HR > HS > CE; edges that lose a same-cycle contest SHALL be discarded, not queued.

REQ-007 Edges detected outside IDLE SHALL be ignored, with no side effects.

REQ-008 CE edge with WE=0:
- capture A into the address register and enter READ with the latency counter at READ_LAT-1;
- when the counter reaches 0, load DOUT from the volatile array at that address and return to IDLE;
- DOUT SHALL be updated and RDY SHALL be 1 at the same edge, exactly READ_LAT cycles after detection.

REQ-009 CE edge with WE=1:
- capture A and DIN and enter WRITE;
- write the array on the first WRITE cycle;
- return to IDLE after WRITE_LAT cycles;
- DOUT SHALL NOT change.

REQ-010 HS edge: enter STORE with the index counter at 0. Each cycle SHALL perform shadow[i] <= array[i] and i++; after i = DEPTH-1 the block SHALL return to IDLE. Total busy time is DEPTH cycles.

REQ-011 HR or POR edge: enter RECALL and perform array[i] <= shadow[i] with the same counter timing as STORE.

REQ-012 The index counter SHALL be AW+1 bits wide, so termination at DEPTH-1 never relies on wrap-around.

REQ-013 DOUT SHALL hold its last value during WRITE, STORE and RECALL.

REQ-014 An access that starts at address DEPTH-1 SHALL behave identically to any other address; there SHALL be no address wrap or aliasing.

Reset
REQ-015 On reset=0, the block SHALL set the following asynchronously:
- state = IDLE, RDY = 1, DOUT = 0;
- all counters = 0;
- edge registers = 0.

REQ-016 Reset SHALL NOT clear either storage array; contents survive reset.

REQ-017 Reset asserted mid-operation SHALL abort the operation. Words already copied remain copied, and the rest are untouched.

REQ-018 After reset is released, an input held high SHALL register as an edge on the first clk.

Structure
REQ-019 State encoding and the default latency constants SHALL be defined in the shared package nvr_pkg.

REQ-020 Edge detection SHALL be one sub-module, nvr_edge_det, instantiated once per strobe input.

REQ-021 Both arrays SHALL be inferred register/RAM arrays without reset, each with a single write port.

Verification
REQ-022 Write 32'hDEADBEEF to A=5, then read A=5:
- DOUT = 32'hDEADBEEF exactly 2 cycles after the read's CE edge;
- RDY low for exactly 2 cycles.

REQ-023 Write 32'h1 to A=127, then read A=127 and A=0:
- A=127 returns 32'h1;
- A=0 is unchanged.

REQ-024 Write 32'hA5A5A5A5 to A=3, pulse HS, write 32'h0 to A=3, pulse HR, read A=3:
- the read returns 32'hA5A5A5A5;
- RDY is low for 128 cycles during each of HS and HR.

REQ-025 HS and CE rise in the same cycle:
- STORE runs and the CE access is dropped;
- a second CE pulsed mid-STORE is ignored, and the array is unchanged.

REQ-026 Assert reset at STORE index 10:
- RDY = 1 and DOUT = 0 immediately;
- shadow[0..9] are updated and shadow[10..127] keep their old values.

REQ-027 POR pulse after loading the shadow array with a known pattern: the volatile array SHALL equal the pattern after 128 cycles.
